// File: rtl/ibtida_top_dffram_cv.sv
// ibtida_top_dffram_cv: UART 8N1 boot loader filling a 256x32 program RAM, then a free-running instruction fetch
// Ports: clock/reset (async active-low); io_rx_i serial in (idle high); io_CLK_PER_BIT cycles per bit;
//   io_rx_byte/io_rx_valid last byte and its one-cycle strobe; io_boot_done set once loading ends;
//   io_pc byte address of current fetch; io_instr word at io_pc (both zero while loading).
module ibtida_top_dffram_cv (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_rx_i,
  input  logic [15:0] io_CLK_PER_BIT,
  output logic [7:0]  io_rx_byte,
  output logic        io_rx_valid,
  output logic        io_boot_done,
  output logic [31:0] io_pc,
  output logic [31:0] io_instr
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic {LOAD, RUN} top_state_t;
  rx_state_t rx_state, rx_next;
  top_state_t state, state_next;
  logic        rx_s1, rx_s2;
  logic [15:0] n, tgt, cnt;
  logic        tick, stop_ok;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [23:0] asm_q;
  logic [1:0]  byte_cnt;
  logic [8:0]  count;
  logic [31:0] word, rdata;
  logic        word_done, is_mark, we, v;
  logic [7:0]  fa;
  logic [31:0] mem [256];
  assign n = io_CLK_PER_BIT < 16'd2 ? 16'd2 : io_CLK_PER_BIT;
  // START waits half a bit to land mid-bit; every later sample is one full bit apart
  assign tgt = rx_state == START ? n >> 1 : n;
  assign tick = cnt == tgt - 16'd1;
  assign stop_ok = rx_state == STOP && tick && rx_s2;
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:    rx_next = rx_s2 ? IDLE : START;
      START:   if (tick) rx_next = rx_s2 ? IDLE : DATA;
      DATA:    if (tick && bit_idx == 3'd7) rx_next = STOP;
      STOP:    if (tick) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end
  // asm_q holds the earlier bytes of the word with the oldest in the low lane once complete
  assign word = {io_rx_byte, asm_q};
  assign word_done = state == LOAD && io_rx_valid && byte_cnt == 2'd3;
  assign is_mark = word == 32'h0000_0FFF;
  assign we = word_done && !is_mark;
  always_comb begin
    state_next = state;
    if (state == LOAD && ((word_done && is_mark && count != 9'd0) || (we && count == 9'd255)))
      state_next = RUN;
  end
  assign io_boot_done = state == RUN;
  assign io_instr = v ? rdata : '0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_state    <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      io_rx_byte  <= '0;
      io_rx_valid <= 1'b0;
      state       <= LOAD;
      asm_q       <= '0;
      byte_cnt    <= '0;
      count       <= '0;
      fa          <= '0;
      v           <= 1'b0;
      io_pc       <= '0;
    end else begin
      rx_s1       <= io_rx_i;
      rx_s2       <= rx_s1;
      rx_state    <= rx_next;
      cnt         <= (rx_state == IDLE || tick) ? '0 : cnt + 16'd1;
      if (rx_state == IDLE) bit_idx <= '0;
      if (rx_state == DATA && tick) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      io_rx_valid <= stop_ok;
      if (stop_ok) io_rx_byte <= shreg;
      state <= state_next;
      if (state == LOAD && io_rx_valid) begin
        asm_q    <= {io_rx_byte, asm_q[23:8]};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (we) count <= count + 9'd1;
      // fa is the word being read this cycle; io_pc is registered alongside the RAM output
      if (state == RUN) fa <= ({1'b0, fa} == count - 9'd1) ? '0 : fa + 8'd1;
      v     <= state == RUN;
      io_pc <= state == RUN ? {22'd0, fa, 2'b00} : '0;
    end
  end
  // program RAM keeps its contents across reset
  always_ff @(posedge clock) begin
    if (we) mem[count[7:0]] <= word;
    rdata <= mem[fa];
  end
endmodule

// File: tb/tb_ibtida_top_dffram_cv.sv
// tb_ibtida_top_dffram_cv: directed checks of the UART boot loader and fetch sequencer
module tb_ibtida_top_dffram_cv;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_rx_i = 1'b1;
  logic [15:0] io_CLK_PER_BIT = 16'd16;
  logic [7:0]  io_rx_byte;
  logic        io_rx_valid;
  logic        io_boot_done;
  logic [31:0] io_pc;
  logic [31:0] io_instr;
  int checks = 0;
  int failures = 0;
  int vcnt = 0;
  int cyc = 0;
  int vcyc = 0;

  ibtida_top_dffram_cv dut (
    .clock(clock), .reset(reset), .io_rx_i(io_rx_i), .io_CLK_PER_BIT(io_CLK_PER_BIT),
    .io_rx_byte(io_rx_byte), .io_rx_valid(io_rx_valid), .io_boot_done(io_boot_done),
    .io_pc(io_pc), .io_instr(io_instr)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc++;
    if (io_rx_valid === 1'b1) begin
      vcnt++;
      vcyc = cyc;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input int per, input int ext, input logic stop);
    @(negedge clock);
    io_rx_i = 1'b0;
    repeat (per + ext) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      io_rx_i = b[i];
      repeat (per) @(negedge clock);
    end
    io_rx_i = stop;
    repeat (per) @(negedge clock);
    io_rx_i = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int per);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], per, 0, 1'b1);
  endtask

  task automatic do_reset(input logic [15:0] n);
    io_rx_i = 1'b1;
    io_CLK_PER_BIT = n;
    @(negedge clock);
    #2 reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(3);
  endtask

  task automatic test_reset;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++; if (io_rx_byte !== 8'h00) begin failures++; $display("FAIL reset_rx_byte got=%h exp=00", io_rx_byte); end
    checks++; if (io_rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", io_rx_valid); end
    checks++; if (io_boot_done !== 1'b0) begin failures++; $display("FAIL reset_boot_done got=%b exp=0", io_boot_done); end
    checks++; if (io_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", io_pc); end
    checks++; if (io_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", io_instr); end
    idle(2);
    reset = 1'b1;
    idle(3);
  endtask

  task automatic test_single_byte;
    int v0, t0, lat;
    do_reset(16'd217);
    v0 = vcnt;
    t0 = cyc;
    send_byte(8'h13, 217, 0, 1'b1);
    idle(4);
    lat = vcyc - t0;
    checks++; if (vcnt - v0 !== 1) begin failures++; $display("FAIL byte13_pulses got=%0d exp=1", vcnt - v0); end
    checks++; if (io_rx_byte !== 8'h13) begin failures++; $display("FAIL byte13_value got=%h exp=13", io_rx_byte); end
    checks++; if (lat < 2050 || lat > 2080) begin failures++; $display("FAIL byte13_latency got=%0d exp=2050..2080", lat); end
  endtask

  task automatic test_stretched_start;
    logic [7:0] bytes [8];
    bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00};
    do_reset(16'd217);
    for (int i = 0; i < 8; i++) send_byte(bytes[i], 215, (i == 0) ? 25 : 0, 1'b1);
    idle(4);
    checks++; if (io_boot_done !== 1'b1) begin failures++; $display("FAIL stretch_boot got=%b exp=1", io_boot_done); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (io_pc !== 32'h0) begin failures++; $display("FAIL stretch_pc got=%h exp=0", io_pc); end
      checks++; if (io_instr !== 32'h13) begin failures++; $display("FAIL stretch_instr got=%h exp=00000013", io_instr); end
      idle(1);
    end
  endtask

  task automatic test_fetch_wrap;
    logic [31:0] tbl [3];
    logic [31:0] exp_pc;
    tbl = '{32'h11111111, 32'h22222222, 32'h33333333};
    do_reset(16'd16);
    for (int i = 0; i < 3; i++) send_word(tbl[i], 16);
    send_word(32'h0000_0FFF, 16);
    idle(4);
    checks++; if (io_boot_done !== 1'b1) begin failures++; $display("FAIL wrap_boot got=%b exp=1", io_boot_done); end
    exp_pc = 32'h0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (io_pc >= 12 || io_pc[1:0] != 2'b00 || io_instr !== tbl[io_pc[3:2]]) begin
        failures++; $display("FAIL wrap_instr pc=%h got=%h exp=word_at_pc", io_pc, io_instr);
      end
      if (i > 0) begin
        checks++; if (io_pc !== exp_pc) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", io_pc, exp_pc); end
      end
      exp_pc = (io_pc == 32'd8) ? 32'd0 : io_pc + 32'd4;
      idle(1);
    end
  endtask

  task automatic test_glitch_framing;
    int v0;
    do_reset(16'd16);
    v0 = vcnt;
    @(negedge clock);
    io_rx_i = 1'b0;
    idle(4);
    io_rx_i = 1'b1;
    idle(40);
    checks++; if (vcnt !== v0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=%0d", vcnt, v0); end
    checks++; if (io_rx_byte !== 8'h00) begin failures++; $display("FAIL glitch_byte got=%h exp=00", io_rx_byte); end
    send_byte(8'h5A, 16, 0, 1'b1);
    idle(4);
    checks++; if (vcnt !== v0 + 1) begin failures++; $display("FAIL after_glitch_pulses got=%0d exp=%0d", vcnt, v0 + 1); end
    checks++; if (io_rx_byte !== 8'h5A) begin failures++; $display("FAIL after_glitch_byte got=%h exp=5a", io_rx_byte); end
    send_byte(8'hA5, 16, 0, 1'b0);
    idle(40);
    checks++; if (vcnt !== v0 + 1) begin failures++; $display("FAIL framing_pulses got=%0d exp=%0d", vcnt, v0 + 1); end
    checks++; if (io_rx_byte !== 8'h5A) begin failures++; $display("FAIL framing_byte got=%h exp=5a", io_rx_byte); end
  endtask

  task automatic test_n_clamp;
    int v0;
    do_reset(16'd1);
    v0 = vcnt;
    send_byte(8'hC3, 2, 0, 1'b1);
    idle(6);
    checks++; if (vcnt !== v0 + 1) begin failures++; $display("FAIL clamp_pulses got=%0d exp=%0d", vcnt, v0 + 1); end
    checks++; if (io_rx_byte !== 8'hC3) begin failures++; $display("FAIL clamp_byte got=%h exp=c3", io_rx_byte); end
  endtask

  task automatic test_marker_first;
    do_reset(16'd16);
    send_word(32'h0000_0FFF, 16);
    idle(4);
    checks++; if (io_boot_done !== 1'b0) begin failures++; $display("FAIL marker_first_boot got=%b exp=0", io_boot_done); end
    send_word(32'hCAFE_F00D, 16);
    send_word(32'h0000_0FFF, 16);
    idle(4);
    checks++; if (io_boot_done !== 1'b1) begin failures++; $display("FAIL marker_then_boot got=%b exp=1", io_boot_done); end
    checks++; if (io_pc !== 32'h0) begin failures++; $display("FAIL marker_pc got=%h exp=0", io_pc); end
    checks++; if (io_instr !== 32'hCAFE_F00D) begin failures++; $display("FAIL marker_instr got=%h exp=cafef00d", io_instr); end
  endtask

  task automatic test_reset_mid_word;
    do_reset(16'd16);
    send_byte(8'hAA, 16, 0, 1'b1);
    send_byte(8'hBB, 16, 0, 1'b1);
    @(negedge clock);
    #2 reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(2);
    send_word(32'h1122_3344, 16);
    send_word(32'h0000_0FFF, 16);
    idle(4);
    checks++; if (io_boot_done !== 1'b1) begin failures++; $display("FAIL midword_boot got=%b exp=1", io_boot_done); end
    checks++; if (io_pc !== 32'h0) begin failures++; $display("FAIL midword_pc got=%h exp=0", io_pc); end
    checks++; if (io_instr !== 32'h1122_3344) begin failures++; $display("FAIL midword_instr got=%h exp=11223344", io_instr); end
  endtask

  task automatic test_fill_256;
    int k;
    do_reset(16'd0);
    for (int i = 0; i < 255; i++) send_word(32'hA500_0000 | i, 2);
    idle(6);
    checks++; if (io_boot_done !== 1'b0) begin failures++; $display("FAIL fill255_boot got=%b exp=0", io_boot_done); end
    send_word(32'hA500_00FF, 2);
    idle(6);
    checks++; if (io_boot_done !== 1'b1) begin failures++; $display("FAIL fill256_boot got=%b exp=1", io_boot_done); end
    k = 0;
    while (io_pc !== 32'd1020 && k < 600) begin
      idle(1);
      k++;
    end
    checks++;
    if (io_pc !== 32'd1020) begin
      failures++; $display("FAIL fill_reach_1020 got=%h exp=3fc", io_pc);
    end else begin
      checks++; if (io_instr !== 32'hA500_00FF) begin failures++; $display("FAIL fill_instr_last got=%h exp=a50000ff", io_instr); end
      idle(1);
      checks++; if (io_pc !== 32'h0) begin failures++; $display("FAIL fill_wrap_pc got=%h exp=0", io_pc); end
      checks++; if (io_instr !== 32'hA500_0000) begin failures++; $display("FAIL fill_wrap_instr got=%h exp=a5000000", io_instr); end
      idle(1);
      checks++; if (io_pc !== 32'h4) begin failures++; $display("FAIL fill_pc4 got=%h exp=4", io_pc); end
      checks++; if (io_instr !== 32'hA500_0001) begin failures++; $display("FAIL fill_instr1 got=%h exp=a5000001", io_instr); end
    end
  endtask

  initial begin
    idle(3);
    test_reset;
    test_single_byte;
    test_stretched_start;
    test_fetch_wrap;
    test_glitch_framing;
    test_n_clamp;
    test_marker_first;
    test_reset_mid_word;
    test_fill_256;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
